// File: rtl/spi_flash_op_seq.sv
// spi_flash_op_seq: WREN -> sector erase / page program -> RDSR poll for a W25Q16.
// Define SEQ_TIMEOUT_EN to bound RDSR polling at POLL_MAX and flag err on timeout.
module spi_flash_op_seq #(
    parameter logic [8:0]  PAGE_BYTES = 9'd256,
    parameter logic [7:0]  POLL_GAP   = 8'd50,
    parameter logic [15:0] POLL_MAX   = 16'd60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_erase,
    input  logic        req_prog,
    input  logic [23:0] addr,
    input  logic [7:0]  wr_byte,
    output logic        data_rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status,
    output logic        spi_start,
    output logic [1:0]  spi_cmd,
    output logic [7:0]  spi_width,
    output logic [31:0] spi_wrdata,
    output logic        spi_keep_cs,
    input  logic [7:0]  spi_rddata,
    input  logic        spi_done
);
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_WRRD = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE, S_WREN_W, S_OP, S_OP_W, S_DREQ, S_DATA, S_DSEND,
        S_DATA_W, S_RDSR, S_RDSR_W, S_GAP, S_DONE
    } state_t;

    state_t      state_q;
    logic        prog_q;
    logic [23:0] addr_q;
    logic [8:0]  cnt_q;
    logic [7:0]  gap_q;
    logic        last_byte;
    logic        gap_last;
    logic        poll_out;

    assign last_byte = (cnt_q == PAGE_BYTES - 9'd1);
    assign gap_last  = ({1'b0, gap_q} + 9'd1 >= {1'b0, POLL_GAP});

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] poll_q;
    assign poll_out = (poll_q >= POLL_MAX);
`else
    logic unused_poll_max;
    assign unused_poll_max = ^POLL_MAX;
    assign poll_out = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prog_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_rd     <= 1'b0;
            status      <= '0;
            spi_start   <= 1'b0;
            spi_cmd     <= '0;
            spi_width   <= '0;
            spi_wrdata  <= '0;
            spi_keep_cs <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            poll_q      <= '0;
            err         <= 1'b0;
`endif
        end else begin
            spi_start <= 1'b0;
            data_rd   <= 1'b0;
            done      <= 1'b0;
            unique case (state_q)
                S_IDLE: if (req_erase || req_prog) begin
                    // WREN is launched from the accept edge itself
                    prog_q      <= ~req_erase;
                    addr_q      <= addr;
                    busy        <= 1'b1;
                    cnt_q       <= '0;
                    spi_start   <= 1'b1;
                    spi_cmd     <= CMD_WR;
                    spi_width   <= 8'd8;
                    spi_wrdata  <= {OP_WREN, 24'h0};
                    spi_keep_cs <= 1'b0;
                    state_q     <= S_WREN_W;
`ifdef SEQ_TIMEOUT_EN
                    poll_q      <= '0;
                    err         <= 1'b0;
`endif
                end
                S_WREN_W: if (spi_done) state_q <= S_OP;
                S_OP: begin
                    spi_start   <= 1'b1;
                    spi_cmd     <= CMD_WR;
                    spi_width   <= 8'd32;
                    spi_wrdata  <= {prog_q ? OP_PP : OP_SE, addr_q};
                    spi_keep_cs <= prog_q;
                    state_q     <= S_OP_W;
                end
                S_OP_W: if (spi_done) state_q <= prog_q ? S_DREQ : S_RDSR;
                S_DREQ: begin
                    data_rd <= 1'b1;
                    state_q <= S_DATA;
                end
                S_DATA: state_q <= S_DSEND;
                S_DSEND: begin
                    spi_start   <= 1'b1;
                    spi_cmd     <= CMD_WR;
                    spi_width   <= 8'd8;
                    spi_wrdata  <= {wr_byte, 24'h0};
                    spi_keep_cs <= ~last_byte;
                    state_q     <= S_DATA_W;
                end
                S_DATA_W: if (spi_done) begin
                    if (last_byte) begin
                        cnt_q   <= '0;
                        state_q <= S_RDSR;
                    end else begin
                        cnt_q   <= cnt_q + 9'd1;
                        state_q <= S_DREQ;
                    end
                end
                S_RDSR: begin
                    spi_start   <= 1'b1;
                    spi_cmd     <= CMD_WRRD;
                    spi_width   <= 8'd8;
                    spi_wrdata  <= {OP_RDSR, 24'h0};
                    spi_keep_cs <= 1'b0;
                    state_q     <= S_RDSR_W;
`ifdef SEQ_TIMEOUT_EN
                    poll_q      <= poll_q + 16'd1;
`endif
                end
                S_RDSR_W: if (spi_done) begin
                    status <= spi_rddata;
                    if (!spi_rddata[0]) begin
                        state_q <= S_DONE;
                    end else if (poll_out) begin
`ifdef SEQ_TIMEOUT_EN
                        err     <= 1'b1;
`endif
                        state_q <= S_DONE;
                    end else begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_last) state_q <= S_RDSR;
                    else          gap_q   <= gap_q + 8'd1;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_op_seq.sv
// Directed bench for spi_flash_op_seq with a small SPI engine and flash status model.
// The timeout case runs only when SEQ_TIMEOUT_EN is defined.
module tb_spi_flash_op_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_erase = 1'b0;
    logic        req_prog = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  wr_byte = '0;
    logic        data_rd, busy, done, err;
    logic [7:0]  status;
    logic        spi_start;
    logic [1:0]  spi_cmd;
    logic [7:0]  spi_width;
    logic [31:0] spi_wrdata;
    logic        spi_keep_cs;
    logic [7:0]  spi_rddata = '0;
    logic        spi_done = 1'b0;

    always #5 clk = ~clk;

    spi_flash_op_seq #(
        .PAGE_BYTES(9'd4), .POLL_GAP(8'd50), .POLL_MAX(16'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_erase(req_erase), .req_prog(req_prog),
        .addr(addr), .wr_byte(wr_byte), .data_rd(data_rd), .busy(busy),
        .done(done), .err(err), .status(status), .spi_start(spi_start),
        .spi_cmd(spi_cmd), .spi_width(spi_width), .spi_wrdata(spi_wrdata),
        .spi_keep_cs(spi_keep_cs), .spi_rddata(spi_rddata), .spi_done(spi_done)
    );

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int req_cyc = 0;

    logic [42:0] tr_log[$];
    int          tr_cyc[$];
    int          eng_cnt = 0;
    logic [7:0]  pend_rd = '0;
    int          rdsr_tot = 0;
    int          st_base = 0;
    int          st_len = 0;
    logic [7:0]  st_seq[4];
    logic [7:0]  st_dflt = '0;
    int          drd_tot = 0;
    int          drd_base = 0;
    logic [7:0]  pg_seq[4];
    int          done_tot = 0;
    int          done_base = 0;
    int          tr_base = 0;
    logic        done_err = 1'b0;
    logic        done_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // engine model: spi_done three cycles after spi_start; RDSR answers from a script
    always @(negedge clk) begin
        spi_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else begin
            if (spi_start) begin
                tr_log.push_back({spi_cmd, spi_width, spi_wrdata, spi_keep_cs});
                tr_cyc.push_back(cyc);
                if (spi_cmd == 2'b01) begin
                    pend_rd = (rdsr_tot - st_base < st_len) ?
                        st_seq[2'(rdsr_tot - st_base)] : st_dflt;
                    rdsr_tot++;
                end
                eng_cnt = 3;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rddata = pend_rd;
                end
            end
            if (data_rd) begin
                wr_byte = pg_seq[2'(drd_tot - drd_base)];
                drd_tot++;
            end
            if (done) begin
                done_tot++;
                done_err = err;
                done_busy = busy;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_test();
        tr_base = tr_log.size();
        st_base = rdsr_tot;
        drd_base = drd_tot;
        done_base = done_tot;
    endtask

    task automatic request(input logic e, input logic p, input logic [23:0] a);
        @(negedge clk);
        req_cyc = cyc;
        req_erase = e;
        req_prog = p;
        addr = a;
        @(negedge clk);
        req_erase = 1'b0;
        req_prog = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_tot - done_base < 1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_tot - done_base), 64'd1);
    endtask

    task automatic chk_tr(input string tag, input int i, input logic [1:0] c,
                          input logic [7:0] w, input logic [31:0] d, input logic k);
        int idx = tr_base + i;
        if (idx < tr_log.size())
            chk(tag, 64'(tr_log[idx]), 64'({c, w, d, k}));
        else
            chk({tag, "_missing"}, 64'(tr_log.size()), 64'(idx + 1));
    endtask

    function automatic logic [63:0] outs();
        return 64'({data_rd, busy, done, err, status, spi_start, spi_cmd,
                    spi_width, spi_wrdata, spi_keep_cs});
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: erase with two busy polls
        begin_test();
        st_seq[0] = 8'h01; st_seq[1] = 8'h01; st_seq[2] = 8'h00; st_seq[3] = 8'h00;
        st_len = 3;
        request(1'b1, 1'b0, 24'h012000);
        wait_done("t1");
        chk("t1_latency", 64'(tr_cyc[tr_base] - req_cyc), 64'd1);
        chk("t1_ntr", 64'(tr_log.size() - tr_base), 64'd5);
        chk_tr("t1_wren", 0, 2'b00, 8'd8, 32'h06000000, 1'b0);
        chk_tr("t1_se", 1, 2'b00, 8'd32, 32'h20012000, 1'b0);
        chk_tr("t1_rdsr0", 2, 2'b01, 8'd8, 32'h05000000, 1'b0);
        chk_tr("t1_rdsr2", 4, 2'b01, 8'd8, 32'h05000000, 1'b0);
        chk("t1_gap1", 64'((tr_cyc[tr_base+3] - tr_cyc[tr_base+2]) >= 50), 64'd1);
        chk("t1_gap2", 64'((tr_cyc[tr_base+4] - tr_cyc[tr_base+3]) >= 50), 64'd1);
        chk("t1_err_busy", {62'd0, done_err, done_busy}, 64'd0);
        chk("t1_status", 64'(status), 64'h00);

        // 2: page program of four bytes
        begin_test();
        st_len = 0; st_dflt = 8'h00;
        pg_seq[0] = 8'hAA; pg_seq[1] = 8'hBB; pg_seq[2] = 8'hCC; pg_seq[3] = 8'hDD;
        request(1'b0, 1'b1, 24'h000100);
        wait_done("t2");
        chk("t2_ntr", 64'(tr_log.size() - tr_base), 64'd7);
        chk_tr("t2_wren", 0, 2'b00, 8'd8, 32'h06000000, 1'b0);
        chk_tr("t2_pp", 1, 2'b00, 8'd32, 32'h02000100, 1'b1);
        chk_tr("t2_b0", 2, 2'b00, 8'd8, 32'hAA000000, 1'b1);
        chk_tr("t2_b1", 3, 2'b00, 8'd8, 32'hBB000000, 1'b1);
        chk_tr("t2_b2", 4, 2'b00, 8'd8, 32'hCC000000, 1'b1);
        chk_tr("t2_b3", 5, 2'b00, 8'd8, 32'hDD000000, 1'b0);
        chk_tr("t2_rdsr", 6, 2'b01, 8'd8, 32'h05000000, 1'b0);
        chk("t2_data_rd", 64'(drd_tot - drd_base), 64'd4);

        // 4: simultaneous requests, erase wins
        begin_test();
        request(1'b1, 1'b1, 24'h003000);
        wait_done("t4");
        repeat (50) @(negedge clk);
        chk("t4_ntr", 64'(tr_log.size() - tr_base), 64'd3);
        chk_tr("t4_se", 1, 2'b00, 8'd32, 32'h20003000, 1'b0);
        chk("t4_data_rd", 64'(drd_tot - drd_base), 64'd0);

        // 5: requests while busy are dropped
        begin_test();
        request(1'b0, 1'b1, 24'h000200);
        repeat (10) @(negedge clk);
        request(1'b1, 1'b1, 24'h000300);
        wait_done("t5");
        repeat (300) @(negedge clk);
        chk("t5_ndone", 64'(done_tot - done_base), 64'd1);
        chk("t5_ntr", 64'(tr_log.size() - tr_base), 64'd7);
        chk_tr("t5_pp", 1, 2'b00, 8'd32, 32'h02000200, 1'b1);
        chk("t5_busy", 64'(busy), 64'd0);

`ifdef SEQ_TIMEOUT_EN
        // 3: WIP stuck, poll limit reached
        begin_test();
        st_len = 0; st_dflt = 8'h01;
        request(1'b1, 1'b0, 24'h000000);
        wait_done("t3");
        chk("t3_err", {62'd0, done_err, err}, 64'd3);
        chk("t3_status", 64'(status), 64'h01);
        repeat (200) @(negedge clk);
        chk("t3_ntr", 64'(tr_log.size() - tr_base), 64'd5);
        st_dflt = 8'h00;
`endif

        // 6: reset during poll gap, then normal erase
        begin_test();
        st_len = 0; st_dflt = 8'h01;
        request(1'b1, 1'b0, 24'h0AB000);
        for (int n = 0; n < 500 && tr_log.size() - tr_base < 3; n++) @(negedge clk);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_reset_outputs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_tr_in_reset", 64'(tr_log.size() - tr_base), 64'd3);
        rst_n = 1'b1;
        st_dflt = 8'h00;
        repeat (2) @(negedge clk);
        begin_test();
        request(1'b1, 1'b0, 24'h0A5000);
        wait_done("t6");
        chk("t6_ntr", 64'(tr_log.size() - tr_base), 64'd3);
        chk_tr("t6_wren", 0, 2'b00, 8'd8, 32'h06000000, 1'b0);
        chk_tr("t6_se", 1, 2'b00, 8'd32, 32'h200A5000, 1'b0);
        chk("t6_err_status", {55'd0, err, status}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
